// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for the multicycle ARM-subset datapath.
// Optional conditional execution (flag register + CondEx) is enabled with `define MULTICYCLE_CTRL_COND_EN.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ToControler,
  input  logic [3:0]  Rd,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmScr,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  if (DATA_WIDTH < 1) begin : gBadWidth
    $error("multicycle_ctrl: DATA_WIDTH must be positive");
  end

  state_t state_q, state_d;
  state_t outState;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       condEx;
  logic       rdIsPc;
  logic [1:0] dpAluCtrl;

  assign cond   = ToControler[11:8];
  assign op     = ToControler[7:6];
  assign funct  = ToControler[5:0];
  assign rdIsPc = (Rd == 4'hF);

`ifdef MULTICYCLE_CTRL_COND_EN
  logic [3:0] flags_q, flags_d;
  logic       flagN, flagZ, flagC, flagV;

  assign {flagN, flagZ, flagC, flagV} = flags_q;

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  // Reaching EXECR/EXECI implies CondEx was true in DECODE, so only the S bit gates the load.
  always_comb begin
    flags_d = flags_q;
    if (((state_q == EXECR) || (state_q == EXECI)) && funct[0]) flags_d = ALUFlags;
  end

  always_comb begin
    condEx = 1'b0;
    case (cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end
`else
  logic unusedCondBits;
  assign unusedCondBits = ^{cond, ALUFlags};
  assign condEx = 1'b1;
`endif

  always_comb begin
    dpAluCtrl = 2'b00;
    case (funct[4:1])
      4'b0100: dpAluCtrl = 2'b00;
      4'b0010: dpAluCtrl = 2'b01;
      4'b0000: dpAluCtrl = 2'b10;
      4'b1100: dpAluCtrl = 2'b11;
      default: dpAluCtrl = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Outputs decode from FETCH while reset is high so no stale write strobe escapes mid-instruction.
  assign outState = reset ? FETCH : state_q;
  assign State    = state_q;
  assign ImmScr   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};

  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;

    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!condEx)            state_d = FETCH;
        else if (op == 2'b01)   state_d = MEMADR;
        else if (op == 2'b00)   state_d = funct[5] ? EXECI : EXECR;
        else if (op == 2'b10)   state_d = BRANCH;
        else                    state_d = FETCH;
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR,
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase

    case (outState)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        PCWrite   = rdIsPc;
        RegWrite  = ~rdIsPc;
      end
      EXECR:  ALUControl = dpAluCtrl;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dpAluCtrl;
      end
      ALUWB: begin
        PCWrite  = rdIsPc;
        RegWrite = ~rdIsPc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction scenarios plus random instructions
// checked against an instruction-level model of state sequences and control outputs.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ToControler;
  logic [3:0]  Rd;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmScr, RegSrc, ALUControl;
  logic [3:0]  State;
  logic [15:0] outsV;

  int checks = 0;
  int failures = 0;
  logic [3:0] modelFlags = 4'b0000;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ToControler(ToControler), .Rd(Rd), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
    .ImmScr(ImmScr), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  assign outsV = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  ResultSrc, ALUSrcB, ImmScr, RegSrc, ALUControl};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word for one named step of an instruction.
  function automatic logic [15:0] expOut(input int s, input logic [11:0] instr, input logic [3:0] rd);
    logic pcw, adr, mw, irw, rw, asa;
    logic [1:0] rs, asb, alu, op;
    logic [3:0] f41;
    op = instr[7:6];
    f41 = instr[4:1];
    {pcw, adr, mw, irw, rw, asa} = 6'b0;
    rs = 0; asb = 0; alu = 0;
    if (s == 6 || s == 7) begin
      if (f41 == 4'b0010)      alu = 2'd1;
      else if (f41 == 4'b0000) alu = 2'd2;
      else if (f41 == 4'b1100) alu = 2'd3;
    end
    if (s == 0) begin irw = 1; pcw = 1; asa = 1; asb = 2; rs = 2; end
    if (s == 1) begin asa = 1; asb = 2; rs = 2; end
    if (s == 2 || s == 7 || s == 9) asb = 1;
    if (s == 3 || s == 5) adr = 1;
    if (s == 5) mw = 1;
    if (s == 4) rs = 1;
    if (s == 4 || s == 8) begin
      if (rd == 4'hF) pcw = 1; else rw = 1;
    end
    if (s == 9) begin rs = 2; pcw = 1; end
    return {pcw, adr, mw, irw, rw, asa, rs, asb, op, (op == 2'b01), (op == 2'b10), alu};
  endfunction

  // Runs one instruction (or its first maxCycles steps), checking State and outputs each cycle.
  task automatic applyStimulus(input logic [11:0] instr, input logic [3:0] rd,
                               input logic [3:0] fl, input int maxCycles);
    int seq[$];
    logic ok;
    logic [1:0] op;
    op = instr[7:6];
    ToControler = instr;
    Rd = rd;
    ALUFlags = fl;
    ok = 1'b1;
`ifdef MULTICYCLE_CTRL_COND_EN
    ok = condHolds(instr[11:8], modelFlags);
`endif
    seq = '{0, 1};
    if (ok) begin
      case (op)
        2'b01: seq = instr[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
        2'b00: seq = instr[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
        2'b10: seq = '{0, 1, 9};
        default: seq = '{0, 1};
      endcase
    end
    for (int i = 0; i < seq.size() && i < maxCycles; i++) begin
      @(negedge clk);
      checkOutput($sformatf("state i=%03h c%0d", instr, i), 32'(State), 32'(seq[i]));
      checkOutput($sformatf("outs i=%03h c%0d", instr, i), 32'(outsV), 32'(expOut(seq[i], instr, rd)));
      @(posedge clk);
      #1;
    end
`ifdef MULTICYCLE_CTRL_COND_EN
    if (maxCycles >= seq.size() && ok && op == 2'b00 && instr[0]) modelFlags = fl;
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [11:0] instr;
    logic [3:0] rd;
    reset = 1'b1;
    ToControler = 12'h000;
    Rd = 4'h0;
    ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset state", 32'(State), 32'd0);
    checkOutput("reset outs", 32'(outsV), 32'(expOut(0, 12'h000, 4'h0)));
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(12'hE3A, 4'h1, 4'h0, 100);
    applyStimulus(12'hE59, 4'h2, 4'h0, 100);
    applyStimulus(12'hE58, 4'h3, 4'h0, 100);
    applyStimulus(12'hE08, 4'hF, 4'h0, 100);
    applyStimulus(12'hE2C, 4'h4, 4'h0, 100);
    applyStimulus(12'hE04, 4'h5, 4'h0, 100);
    applyStimulus(12'hEC0, 4'h5, 4'h0, 100);
    applyStimulus(12'hE59, 4'hF, 4'h0, 100);

`ifdef MULTICYCLE_CTRL_COND_EN
    applyStimulus(12'hE05, 4'h1, 4'b0100, 100);
    applyStimulus(12'h1A0, 4'h0, 4'b0000, 100);
    applyStimulus(12'h0A0, 4'h0, 4'b0000, 100);
    applyStimulus(12'hFA0, 4'h0, 4'b0000, 100);
`endif

    // Reset while the LDR sits in MEMRD.
    applyStimulus(12'hE59, 4'h2, 4'h0, 3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset state", 32'(State), 32'd3);
    checkOutput("midreset outs", 32'(outsV), 32'(expOut(0, 12'hE59, 4'h2)));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("postreset state", 32'(State), 32'd0);
    checkOutput("postreset writes", 32'({MemWrite, RegWrite}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelFlags = 4'b0000;

    for (int k = 0; k < 60; k++) begin
      instr = 12'($urandom_range(0, 4095));
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      applyStimulus(instr, rd, 4'($urandom_range(0, 15)), 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
